// File: rtl/cpu_resets.sv
// cpu_resets
//   Reset control for the CPU core. Samples the external reset pin on clk and
//   produces the internal active-low core reset. It also implements the
//   single-clock "special reset": a one-clock pin pulse seen at M1/T1 loads
//   zero into the PC without resetting the rest of the core.
//
// Ports
//   clk          CPU clock, all state updates on the rising edge
//   nfpga_reset  asynchronous active-low power-on/init reset
//   reset_in     external reset pin, active-high, synchronous to clk
//   M1           sequencer: current machine cycle is M1 (opcode fetch)
//   T2           sequencer: current T-state is T2
//   clrpc        registered, active-high: load 0 into the PC
//   nreset       registered, active-low internal core reset
module cpu_resets (
  input  logic clk,
  input  logic nfpga_reset,
  input  logic reset_in,
  input  logic M1,
  input  logic T2,
  output logic clrpc,
  output logic nreset
);

  logic rs1;        // reset_in sampled at the most recent edge
  logic rs2;        // reset_in sampled one edge before that
  logic spec_pend;  // special reset issued last edge, may still turn full

  logic spec_set;
  logic spec_cancel;
  logic pc_release;
  logic nreset_nxt;
  logic clrpc_nxt;
  logic spec_pend_nxt;

  always_comb begin
    // A pin pulse that was low last edge, seen at M1/T1 while the core is
    // running, is a special-reset candidate.
    spec_set    = reset_in & ~rs1 & M1 & ~T2 & nreset;
    // The pin stayed high for a second edge after the candidate edge: this
    // is really a full reset, so the PC-only clear is withdrawn. rs1/rs2
    // describe the rising pin edge that raised spec_pend.
    spec_cancel = spec_pend & reset_in & rs1 & ~rs2;
    pc_release  = M1 & T2;

    nreset_nxt = nreset;
    if (reset_in && rs1)
      nreset_nxt = 1'b0;
    else if (!reset_in && !rs1)
      nreset_nxt = 1'b1;

    // Set has priority over release; the full reset clears the PC itself,
    // so clrpc is held off whenever the core is in reset.
    clrpc_nxt = clrpc;
    if (!nreset)
      clrpc_nxt = 1'b0;
    else if (spec_set)
      clrpc_nxt = 1'b1;
    else if (spec_cancel)
      clrpc_nxt = 1'b0;
    else if (pc_release)
      clrpc_nxt = 1'b0;

    spec_pend_nxt = spec_set;
  end

  always_ff @(posedge clk or negedge nfpga_reset) begin
    if (!nfpga_reset) begin
      rs1       <= 1'b0;
      rs2       <= 1'b0;
      nreset    <= 1'b0;
      clrpc     <= 1'b0;
      spec_pend <= 1'b0;
    end else begin
      rs1       <= reset_in;
      rs2       <= rs1;
      nreset    <= nreset_nxt;
      clrpc     <= clrpc_nxt;
      spec_pend <= spec_pend_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_resets.sv
module tb_cpu_resets;

  logic clk;
  logic nfpga_reset;
  logic reset_in;
  logic M1;
  logic T2;
  logic clrpc;
  logic nreset;

  typedef struct {
    string name;
    logic  exp_clrpc;
    logic  exp_nreset;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 0;

  cpu_resets dut (
    .clk        (clk),
    .nfpga_reset(nfpga_reset),
    .reset_in   (reset_in),
    .M1         (M1),
    .T2         (T2),
    .clrpc      (clrpc),
    .nreset     (nreset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every falling edge, compare the outputs against the oldest
  // pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (clrpc !== e.exp_clrpc || nreset !== e.exp_nreset) begin
        errors++;
        $display("FAIL %s: got clrpc=%b nreset=%b, expected clrpc=%b nreset=%b",
                 e.name, clrpc, nreset, e.exp_clrpc, e.exp_nreset);
      end
    end
  end

  function automatic void expect_out(input string name, input logic c, input logic n);
    exp_t e;
    e.name       = name;
    e.exp_clrpc  = c;
    e.exp_nreset = n;
    exp_q.push_back(e);
  endfunction

  // Drive one clock of inputs; after the rising edge, optionally queue the
  // outputs that edge should produce.
  task automatic step(input logic ri, input logic m1, input logic t2,
                      input bit chk, input logic c, input logic n,
                      input string name);
    reset_in = ri;
    M1       = m1;
    T2       = t2;
    @(posedge clk);
    if (chk) expect_out(name, c, n);
    @(negedge clk);
  endtask

  initial begin
    nfpga_reset = 1'b0;
    reset_in    = 1'b0;
    M1          = 1'b0;
    T2          = 1'b0;

    // Power-on
    step(0, 0, 0, 1, 0, 0, "por_hold");
    step(0, 0, 0, 1, 0, 0, "por_hold2");
    nfpga_reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, "");
    step(0, 0, 0, 1, 0, 1, "por_release");
    step(0, 0, 0, 1, 0, 1, "idle");

    // Normal full reset, pin high 3 clocks
    step(1, 0, 0, 1, 0, 1, "nr_edge1");
    step(1, 0, 0, 1, 0, 0, "nr_edge2");
    step(1, 0, 0, 1, 0, 0, "nr_edge3");
    step(0, 0, 0, 1, 0, 0, "nr_low1");
    step(0, 0, 0, 1, 0, 1, "nr_low2");

    // Special reset, released by the very next M1/T2 edge
    step(1, 1, 0, 1, 1, 1, "sp_set");
    step(0, 1, 1, 1, 0, 1, "sp_rel_next");
    step(0, 1, 0, 1, 0, 1, "sp_after");

    // Special reset held until a later M1/T2
    step(1, 1, 0, 1, 1, 1, "sp2_set");
    step(0, 0, 0, 1, 1, 1, "sp2_hold1");
    step(0, 1, 0, 1, 1, 1, "sp2_hold2");
    step(0, 0, 1, 1, 1, 1, "sp2_hold_t2only");
    step(0, 1, 1, 1, 0, 1, "sp2_release");
    step(0, 0, 0, 1, 0, 1, "sp2_idle");

    // Single-clock pulses outside M1/T1 are ignored
    step(1, 0, 0, 1, 0, 1, "out_m0_pulse");
    step(0, 0, 0, 1, 0, 1, "out_m0_after1");
    step(0, 0, 0, 1, 0, 1, "out_m0_after2");
    step(1, 1, 1, 1, 0, 1, "out_t2_pulse");
    step(0, 1, 1, 1, 0, 1, "out_t2_after1");
    step(0, 0, 0, 1, 0, 1, "out_t2_after2");

    // Special reset turning into a full reset
    step(1, 1, 0, 1, 1, 1, "sf_set");
    step(1, 1, 0, 1, 0, 0, "sf_cancel");
    step(1, 1, 0, 1, 0, 0, "sf_held");
    step(0, 0, 0, 1, 0, 0, "sf_low1");
    step(0, 0, 0, 1, 0, 1, "sf_low2");

    // Asynchronous abort while clrpc is high
    step(1, 1, 0, 1, 1, 1, "ab_set");
    reset_in = 1'b0;
    M1       = 1'b0;
    T2       = 1'b0;
    @(posedge clk);
    expect_out("ab_clrpc_held", 1, 1);
    @(posedge clk);
    #2;
    nfpga_reset = 1'b0;
    expect_out("ab_async", 0, 0);
    @(negedge clk);
    step(0, 0, 0, 1, 0, 0, "ab_in_reset");
    nfpga_reset = 1'b1;
    step(0, 0, 0, 0, 0, 0, "");
    step(0, 0, 0, 1, 0, 1, "ab_recover");

    repeat (3) @(negedge clk);
    stim_done = 1;
  end

  initial begin
    fork
      begin
        wait (stim_done);
        #1;
      end
      begin
        #50000;
        errors++;
        $display("FAIL timeout: stimulus did not complete, expected completion");
      end
    join_any
    disable fork;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
